// File: rtl/register_file_mp_pkg.sv
// Shared constants and sweep-FSM state encoding for the multi-port register file.
package register_file_mp_pkg;

  localparam int WORD      = 64;
  localparam int XZR_INDEX = 31;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/register_file_mp_clear_seq.sv
// Zeroing-sweep sequencer: walks idx 0..DEPTH-1 once per clear request or reset,
// issuing one zero write per cycle; busy is high for exactly DEPTH cycles.
module regfile_clear_seq
  import register_file_mp_pkg::*;
#(
  parameter int  DEPTH = XZR_INDEX + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          read_clk,
  input  logic          reset,
  input  logic          clear,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // Reset lands in CLEAR so the array is always swept before first use.
  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  assign busy    = (state_q == CLEAR);
  assign clr_idx = idx_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with registered reads and a hardware zeroing sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int  WIDTH    = WORD,
  parameter int  DEPTH    = XZR_INDEX + 1,
  parameter int  NUM_RD   = 2,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                    read_clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    reg_write,
  input  logic [AW-1:0]           write_reg,
  input  logic [WIDTH-1:0]        write_data,
  input  logic [NUM_RD*AW-1:0]    read_reg,
  output logic [NUM_RD*WIDTH-1:0] read_data,
  output logic                    busy
);

  localparam logic [AW-1:0] XZR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok;

  regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .read_clk (read_clk),
    .reset    (reset),
    .clear    (clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  assign wr_ok = reg_write && !busy && !((ZERO_REG != 0) && (write_reg == XZR));

  // The array has no reset; only the sweep zeroes it.
  always_ff @(posedge read_clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[write_reg] <= write_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    ra_p0;
    logic [WIDTH-1:0] rd_p0;
    logic [WIDTH-1:0] rd_p1;

    assign ra_p0 = read_reg[p*AW +: AW];

    always_comb begin
      rd_p0 = mem[ra_p0];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (ra_p0 == write_reg)) begin
        rd_p0 = write_data;
      end
`endif
      if ((ZERO_REG != 0) && (ra_p0 == XZR)) begin
        rd_p0 = '0;
      end
    end

    // p0 -> p1: registered read, blanked while sweeping
    always_ff @(posedge read_clk or posedge reset) begin
      if (reset) begin
        rd_p1 <= '0;
      end else if (busy) begin
        rd_p1 <= '0;
      end else begin
        rd_p1 <= rd_p0;
      end
    end

    assign read_data[p*WIDTH +: WIDTH] = rd_p1;
  end

endmodule
